// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch front end: program counter, IF/ID pipeline register and a
// return-address stack. Redirects (jump, return, relative branch) take
// priority over stall; stall takes priority over normal sequential fetch.
module pipe_fetch_stage #(
  parameter int              PC_W      = 12,
  parameter int              INS_W     = 19,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  localparam int             CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INS_W-1:0]   imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_kind,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic [PC_W-1:0]    redirect_base,
  input  logic [OFF_W-1:0]   redirect_offset,
  input  logic               push_valid,
  input  logic [PC_W-1:0]    push_addr,
  output logic [PC_W-1:0]    pc,
  output logic               ifid_valid,
  output logic [INS_W-1:0]   ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus1,
  output logic [CNT_W-1:0]   ras_count,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int IDX_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_RETURN = 2'b10;
  localparam logic [1:0] KIND_BRANCH = 2'b11;

  // Request handshake: redirect_valid and push_valid are strobes with no
  // ready; the block accepts a request on every rising edge where its valid
  // is high and never applies backpressure. Payload fields are only looked at
  // while the matching valid is high.

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  ret_target;
  logic [PC_W-1:0]  next_target;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             redirect_eff;
  logic             ret_req;
  logic             ras_empty;
  logic             ras_full;

  assign imem_addr     = pc;
  assign pc_plus1      = pc + PC_W'(1);
  assign off_ext       = PC_W'($signed(redirect_offset));
  assign branch_target = redirect_base + off_ext;

  assign redirect_eff  = redirect_valid && (redirect_kind != 2'b00);
  assign ret_req       = redirect_valid && (redirect_kind == KIND_RETURN);

  assign ras_empty     = (ras_count == '0);
  assign ras_full      = (ras_count == CNT_W'(RAS_DEPTH));
  // top_idx is only meaningful while the stack is non-empty.
  assign top_idx       = IDX_W'(ras_count - CNT_W'(1));
  // push_idx is only used while the stack is not full, so it always fits.
  assign push_idx      = IDX_W'(ras_count);
  assign ras_top       = ras_mem[top_idx];
  assign ret_target    = ras_empty ? RESET_PC : ras_top;

  // Select the redirect destination by kind.
  always_comb begin
    next_target = redirect_target;
    case (redirect_kind)
      KIND_JUMP:   next_target = redirect_target;
      KIND_RETURN: next_target = ret_target;
      KIND_BRANCH: next_target = branch_target;
      default:     next_target = redirect_target;
    endcase
  end

  // PC and IF/ID register: redirect beats stall, stall beats sequential fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc_plus1 <= '0;
    end else if (redirect_eff) begin
      // The instruction fetched this cycle is on the wrong path.
      pc         <= next_target;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
    end else if (stall) begin
      if (flush) begin
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end
    end else begin
      pc            <= pc_plus1;
      ifid_instr    <= flush ? '0 : imem_data;
      ifid_pc_plus1 <= pc_plus1;
      ifid_valid    <= ~flush;
    end
  end

  // Return-stack storage; a push together with a return overwrites the top.
  always_ff @(posedge clk) begin
    if (push_valid) begin
      if (ret_req && !ras_empty) begin
        ras_mem[top_idx] <= push_addr;
      end else if (!ras_full) begin
        ras_mem[push_idx] <= push_addr;
      end
    end
  end

  // Return-stack occupancy and sticky overflow/underflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      case ({push_valid, ret_req})
        2'b11: begin
          if (ras_empty) begin
            ras_count     <= CNT_W'(1);
            ras_underflow <= 1'b1;
          end
        end
        2'b10: begin
          if (ras_full) ras_overflow <= 1'b1;
          else          ras_count    <= ras_count + CNT_W'(1);
        end
        2'b01: begin
          if (ras_empty) ras_underflow <= 1'b1;
          else           ras_count     <= ras_count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Bench for pipe_fetch_stage: directed stimulus, a queue-based reference
// model compared on every falling edge, plus hand-computed literal checks.
module tb_pipe_fetch_stage;

  localparam int              PC_W      = 12;
  localparam int              INS_W     = 19;
  localparam int              OFF_W     = 8;
  localparam int              RAS_DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_PC  = '0;
  localparam int              CNT_W     = $clog2(RAS_DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_data;
  logic             stall, flush;
  logic             redirect_valid;
  logic [1:0]       redirect_kind;
  logic [PC_W-1:0]  redirect_target, redirect_base;
  logic [OFF_W-1:0] redirect_offset;
  logic             push_valid;
  logic [PC_W-1:0]  push_addr;
  logic [PC_W-1:0]  pc;
  logic             ifid_valid;
  logic [INS_W-1:0] ifid_instr;
  logic [PC_W-1:0]  ifid_pc_plus1;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow, ras_underflow;

  always #5 clk = ~clk;

  function automatic logic [INS_W-1:0] imem_fn(input logic [PC_W-1:0] a);
    return {a[6:0], a} ^ 19'h2A5A5;
  endfunction

  assign imem_data = imem_fn(imem_addr);

  pipe_fetch_stage #(
    .PC_W(PC_W), .INS_W(INS_W), .OFF_W(OFF_W),
    .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_target(redirect_target), .redirect_base(redirect_base),
    .redirect_offset(redirect_offset),
    .push_valid(push_valid), .push_addr(push_addr),
    .pc(pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PC_W-1:0]  m_pc, m_pc1;
  logic             m_valid;
  logic [INS_W-1:0] m_instr;
  logic [PC_W-1:0]  m_ras[$];
  logic             m_ovf, m_unf;

  always @(posedge clk or negedge rst) begin : model
    logic [PC_W-1:0] tgt;
    logic            eff, ret;
    if (!rst) begin
      m_pc = RESET_PC; m_pc1 = '0; m_valid = 1'b0; m_instr = '0;
      m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      eff = redirect_valid && (redirect_kind != 2'b00);
      ret = redirect_valid && (redirect_kind == 2'b10);
      case (redirect_kind)
        2'b01:   tgt = redirect_target;
        2'b11:   tgt = PC_W'(int'(redirect_base) + int'($signed(redirect_offset)));
        default: tgt = (m_ras.size() > 0) ? m_ras[$] : RESET_PC;
      endcase
      if (push_valid && ret) begin
        if (m_ras.size() == 0) begin m_ras.push_back(push_addr); m_unf = 1'b1; end
        else m_ras[m_ras.size()-1] = push_addr;
      end else if (push_valid) begin
        if (m_ras.size() < RAS_DEPTH) m_ras.push_back(push_addr);
        else m_ovf = 1'b1;
      end else if (ret) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
      end
      if (eff) begin
        m_pc = tgt; m_valid = 1'b0; m_instr = '0;
      end else if (stall) begin
        if (flush) begin m_valid = 1'b0; m_instr = '0; end
      end else begin
        m_instr = flush ? '0 : imem_fn(m_pc);
        m_valid = !flush;
        m_pc1   = m_pc + PC_W'(1);
        m_pc    = m_pc + PC_W'(1);
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      check("ifid_instr", 32'(ifid_instr), 32'(m_instr));
      if (m_valid) check("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_pc1));
      check("ras_count", 32'(ras_count), 32'(m_ras.size()));
      check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_kind = 2'b00;
    redirect_target = '0; redirect_base = '0; redirect_offset = '0;
    push_valid = 0; push_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir(input logic [1:0] kind, input logic [PC_W-1:0] tgt,
                       input logic [PC_W-1:0] base, input logic [OFF_W-1:0] off);
    redirect_valid = 1; redirect_kind = kind;
    redirect_target = tgt; redirect_base = base; redirect_offset = off;
  endtask

  task automatic no_redir();
    redirect_valid = 0; redirect_kind = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(RESET_PC));
    check({tag, "_valid"}, 32'(ifid_valid), 32'h0);
    check({tag, "_instr"}, 32'(ifid_instr), 32'h0);
    check({tag, "_pc1"}, 32'(ifid_pc_plus1), 32'h0);
    check({tag, "_count"}, 32'(ras_count), 32'h0);
    check({tag, "_ovf"}, 32'(ras_overflow), 32'h0);
    check({tag, "_unf"}, 32'(ras_underflow), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  logic [PC_W-1:0] push_list [5] = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055};
  logic [PC_W-1:0] pop_list  [4] = '{12'h044, 12'h033, 12'h022, 12'h011};

  initial begin
    rst = 1'b0;
    clear_inputs();
    #12;
    check_reset_values("rst0");
    rst = 1'b1;

    // Free-running fetch from RESET_PC.
    tick();
    check("run1_pc", 32'(pc), 32'h001);
    check("run1_pc1", 32'(ifid_pc_plus1), 32'h001);
    check("run1_valid", 32'(ifid_valid), 32'h1);
    check("run1_instr", 32'(ifid_instr), 32'h2A5A5);
    tick(); tick(); tick();
    check("run4_pc", 32'(pc), 32'h004);
    check("run4_pc1", 32'(ifid_pc_plus1), 32'h004);
    tick();
    check("run5_pc", 32'(pc), 32'h005);

    // Two stalled cycles hold everything.
    stall = 1;
    tick(); tick();
    check("stall_pc", 32'(pc), 32'h005);
    check("stall_pc1", 32'(ifid_pc_plus1), 32'h005);
    check("stall_instr", 32'(ifid_instr), 32'(imem_fn(12'h004)));
    check("stall_valid", 32'(ifid_valid), 32'h1);

    // Jump overrides stall, then one bubble.
    redir(2'b01, 12'h100, '0, '0);
    tick();
    check("jump_pc", 32'(pc), 32'h100);
    check("jump_valid", 32'(ifid_valid), 32'h0);
    no_redir(); stall = 0;
    tick();
    check("jump_next_pc", 32'(pc), 32'h101);
    check("jump_next_valid", 32'(ifid_valid), 32'h1);
    check("jump_next_instr", 32'(ifid_instr), 32'(imem_fn(12'h100)));

    // Relative branches, negative offset and wrap-around.
    redir(2'b11, '0, 12'h010, 8'hFC);
    tick();
    check("br_neg_pc", 32'(pc), 32'h00C);
    check("br_neg_valid", 32'(ifid_valid), 32'h0);
    no_redir();
    tick();
    check("br_neg_next_pc", 32'(pc), 32'h00D);
    check("br_neg_next_instr", 32'(ifid_instr), 32'(imem_fn(12'h00C)));
    redir(2'b11, '0, 12'hFFF, 8'h02);
    tick();
    check("br_wrap_pc", 32'(pc), 32'h001);
    no_redir();
    tick();
    check("br_wrap_next_pc", 32'(pc), 32'h002);

    // Sequential PC wrap from all-ones.
    redir(2'b01, 12'hFFF, '0, '0);
    tick();
    no_redir();
    tick();
    check("pcwrap_pc", 32'(pc), 32'h000);
    check("pcwrap_pc1", 32'(ifid_pc_plus1), 32'h000);
    check("pcwrap_instr", 32'(ifid_instr), 32'(imem_fn(12'hFFF)));

    // Flush on a normal cycle, then flush during stall.
    flush = 1;
    tick();
    check("flush_pc", 32'(pc), 32'h001);
    check("flush_valid", 32'(ifid_valid), 32'h0);
    check("flush_instr", 32'(ifid_instr), 32'h0);
    flush = 0;
    tick();
    stall = 1; flush = 1;
    tick();
    check("stflush_pc", 32'(pc), 32'h002);
    check("stflush_valid", 32'(ifid_valid), 32'h0);
    stall = 0; flush = 0;

    // Fill the RAS past its depth.
    for (int i = 0; i < 5; i++) begin
      push_valid = 1; push_addr = push_list[i];
      tick();
      if (i == 3) begin
        check("fill_count", 32'(ras_count), 32'h4);
        check("fill_ovf", 32'(ras_overflow), 32'h0);
      end
    end
    push_valid = 0;
    check("ovf_count", 32'(ras_count), 32'h4);
    check("ovf_flag", 32'(ras_overflow), 32'h1);

    // Drain with returns, then underflow.
    for (int i = 0; i < 4; i++) begin
      redir(2'b10, '0, '0, '0);
      tick();
      check("ret_pc", 32'(pc), 32'(pop_list[i]));
      check("ret_count", 32'(ras_count), 32'(3 - i));
    end
    tick();
    check("unf_pc", 32'(pc), 32'(RESET_PC));
    check("unf_flag", 32'(ras_underflow), 32'h1);
    no_redir();

    // Refill two entries; the second push happens while stalled.
    push_valid = 1; push_addr = 12'h033;
    tick();
    stall = 1; push_addr = 12'h044;
    tick();
    check("stall_push_count", 32'(ras_count), 32'h2);
    stall = 0; push_valid = 0;

    // Return kind without redirect_valid does not pop.
    redirect_valid = 0; redirect_kind = 2'b10;
    tick();
    check("nopop_count", 32'(ras_count), 32'h2);

    // Push and return together replace the top.
    push_valid = 1; push_addr = 12'h0AA;
    redir(2'b10, '0, '0, '0);
    tick();
    push_valid = 0;
    check("pushret_pc", 32'(pc), 32'h044);
    check("pushret_count", 32'(ras_count), 32'h2);
    tick();
    check("pushret_next_pc", 32'(pc), 32'h0AA);
    tick();
    check("pushret_last_pc", 32'(pc), 32'h033);
    no_redir();

    // Asynchronous reset in the middle of a redirect with three entries.
    for (int i = 0; i < 3; i++) begin
      push_valid = 1; push_addr = PC_W'(i + 1);
      tick();
    end
    push_valid = 0;
    check("pre_rst_count", 32'(ras_count), 32'h3);
    redir(2'b01, 12'h200, '0, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    clear_inputs();
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("post_rst_pc", 32'(pc), 32'h001);

    // Push and return together on an empty stack.
    push_valid = 1; push_addr = 12'h0BB;
    redir(2'b10, '0, '0, '0);
    tick();
    push_valid = 0;
    check("empty_pushret_pc", 32'(pc), 32'(RESET_PC));
    check("empty_pushret_count", 32'(ras_count), 32'h1);
    check("empty_pushret_unf", 32'(ras_underflow), 32'h1);
    tick();
    check("empty_pushret_next_pc", 32'(pc), 32'h0BB);
    check("empty_pushret_next_count", 32'(ras_count), 32'h0);
    clear_inputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_stage.md
# pipe_fetch_stage

Parametrised instruction-fetch front end for the pipelined processor: owns the program counter, the IF/ID pipeline register and a configurable-depth return-address stack. Adds stall, flush and prioritised redirect (jump, return, relative branch) with explicit overflow/underflow reporting. Sits between the instruction memory and the decode stage; redirect requests arrive from later pipeline stages.

## Interface
- PC_W, 12, program-counter and instruction-address width
- INS_W, 19, instruction width
- OFF_W, 8, signed branch-offset width (OFF_W <= PC_W)
- RAS_DEPTH, 4, return-address stack entries (>= 2)
- RESET_PC, 0, PC value after reset and on return-underflow

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous and active-low
- imem_addr  out  PC_W  instruction-memory address, equals pc (combinational)
- imem_data  in  INS_W  instruction read from imem_addr, same cycle
- stall  in  1  hold PC and IF/ID register
- flush  in  1  invalidate IF/ID register
- redirect_valid  in  1  change control flow
- redirect_kind  in  2  01 jump absolute, 10 return (pop RAS), 11 branch relative, 00 ignored
- redirect_target  in  PC_W  absolute jump target
- redirect_base  in  PC_W  base PC for relative branch
- redirect_offset  in  OFF_W  signed branch offset
- push_valid  in  1  push push_addr onto RAS (call)
- push_addr  in  PC_W  return address to push
- pc  out  PC_W  current fetch PC
- ifid_valid  out  1  IF/ID register holds a live instruction
- ifid_instr  out  INS_W  fetched instruction
- ifid_pc_plus1  out  PC_W  fetch PC + 1
- ras_count  out  $clog2(RAS_DEPTH+1)  occupied RAS entries
- ras_overflow  out  1  sticky: push attempted while full
- ras_underflow  out  1  sticky: return attempted while empty

## Operation
- Reset (rst low, immediate): pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc_plus1=0, ras_count=0, both sticky flags 0; RAS contents don't-care.
- Effective redirect: redirect_valid=1 and redirect_kind!=00.
- Per-cycle priority: effective redirect > stall > normal.
  - Redirect: pc <= target; ifid_valid <= 0, ifid_instr <= 0 (wrong-path fetch discarded). Overrides stall.
  - Stall (no redirect): pc and IF/ID register hold; flush still clears ifid_valid/ifid_instr.
  - Normal: pc <= pc+1; ifid_instr <= imem_data, ifid_pc_plus1 <= pc+1, ifid_valid <= ~flush (flush=1 loads 0 into ifid_instr).
- Targets: jump = redirect_target; branch = redirect_base + sign-extended redirect_offset, modulo 2^PC_W; return = RAS top, or RESET_PC if empty.
- All PC arithmetic wraps modulo 2^PC_W (pc all-ones + 1 = 0).
- RAS (LIFO, ras_count entries, top = last pushed):
  - Push only: if count<RAS_DEPTH, store push_addr, count+1; else drop, set ras_overflow.
  - Return only: if count>0, target = top, count-1; else set ras_underflow.
  - Push and return same cycle: target = current top, push_addr replaces top, count unchanged; if empty, push_addr is stored (count 0->1), target = RESET_PC, ras_underflow set.
  - Push is independent of stall; a return with redirect_valid=0 does not pop.
- Sticky flags clear only on reset.

## Timing
- imem_addr follows pc combinationally; instruction memory is asynchronous-read.
- Fetch latency: instruction at pc appears on ifid_instr one cycle later.
- Redirect penalty: redirect sampled at edge N; pc=target after N; first valid instruction from target on ifid at edge N+1; exactly one bubble.
- RAS updates and flags visible the cycle after the triggering edge.
- Reset deassertion: first fetch at RESET_PC on first rising edge with rst high.

## Test plan
- Reset then 4 free-running cycles, imem_data=pc-derived pattern -> pc 0,1,2,3,4; ifid_pc_plus1 1..4; ifid_valid 0 then 1 from cycle 1.
- Stall held 2 cycles at pc=5 with flush=0 -> pc stays 5, ifid unchanged; stall+redirect jump to 0x100 -> pc=0x100, ifid_valid=0.
- Branch base=0x010, offset=0xFC (-4) -> pc=0x00C; base=0xFFF, offset=0x02 -> pc=0x001 (wrap); one bubble each.
- Push 0x011,0x022,0x033,0x044,0x055 (depth 4) -> count 4, ras_overflow=1; four returns -> pc 0x044,0x033,0x022,0x011; fifth return -> pc=RESET_PC, ras_underflow=1.
- Push 0x0AA with return same cycle, top=0x044 -> pc=0x044, count unchanged, next return -> 0x0AA.
- rst asserted mid-redirect and with count=3 -> outputs immediately at reset values, count=0, flags 0.
